// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch datapath: opcodes, IR field positions, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sisc_pkg;

    // Opcode map (IR[31:28])
    localparam logic [3:0] OP_NOOP = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LOD  = 4'h2;
    localparam logic [3:0] OP_STR  = 4'h3;
    localparam logic [3:0] OP_BRA  = 4'h4;
    localparam logic [3:0] OP_BRR  = 4'h5;
    localparam logic [3:0] OP_BNE  = 4'h6;
    localparam logic [3:0] OP_BNR  = 4'h7;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // IR field positions
    localparam int OPCODE_LSB = 28;
    localparam int MM_LSB     = 24;
    localparam int RD_LSB     = 20;
    localparam int RS_LSB     = 16;
    localparam int RT_LSB     = 12;
    localparam int IMM_LSB    = 0;
    localparam int FIELD_W    = 4;
    localparam int IMM_W      = 16;

    // IR value after reset: a NOOP with all other fields zero
    localparam logic [31:0] IR_RESET = {OP_NOOP, 28'h0};

    // Fetch FSM: ST_PREF is only reachable when the prefetch buffer is built in
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PREF = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sisc_prefetch_buf.sv
// One-entry instruction prefetch buffer {addr, data, valid} with tag compare against a lookup address.
// Latency: fill visible next cycle; hit/rd_data are combinational from the stored entry.
// Backpressure: none; invalidate and consume both clear the entry, fill is ignored by the caller when either applies.
// Ports: clk/rst_f; fill/fill_addr/fill_data write the entry; inval, consume clear it;
//        lookup_addr is compared against the stored tag -> hit, rd_data returns the stored word.
module sisc_prefetch_buf
    import sisc_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    input  logic          inval,
    input  logic          consume,
    input  logic [AW-1:0] lookup_addr,
    output logic          hit,
    output logic [DW-1:0] rd_data
);

    logic          valid;
    logic [AW-1:0] tag;
    logic [DW-1:0] data_r;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            valid  <= 1'b0;
            tag    <= '0;
            data_r <= '0;
        end else begin
            if (fill) begin
                valid  <= 1'b1;
                tag    <= fill_addr;
                data_r <= fill_data;
            end
            // Clearing wins over a simultaneous fill
            if (inval || consume) begin
                valid <= 1'b0;
            end
        end
    end

    assign hit     = valid && (tag == lookup_addr);
    assign rd_data = data_r;

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: owns PC and IR, fetches instruction words over imem req/ack, decodes IR fields.
// Latency: ir_load -> IR valid in 2 clks minimum (0 stall on a prefetch hit when SISC_PREFETCH_EN is defined).
// Backpressure: fetch_busy holds the controller in its fetch state until the word is taken; imem_req held until imem_ack.
// Ports: clk, rst_f (async active-low); pc_rst/pc_write/pc_sel/br_sel/ir_load control inputs;
//        imem_req/imem_addr/imem_ack/imem_rdata memory handshake; fetch_busy; pc; opcode/mm/rd/rs/rt/imm IR fields.
// Build option: define SISC_PREFETCH_EN for the one-entry sequential prefetch buffer.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter int              INSTR_W   = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               fetch_busy,
    output logic [PC_W-1:0]    pc,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [3:0]         rd,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [15:0]        imm
);

    fetch_state_e       state;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    pc_next;
    logic [PC_W-1:0]    imm_sext;
    logic [PC_W-1:0]    imm_abs;
    logic               pc_upd_en;
    // A pc_rst seen during a demand fetch makes the returning word stale
    logic               discard;

    // ------------------------------------------------------------------
    // PC update (shared by both builds; pc_upd_en differs)
    // ------------------------------------------------------------------
    assign imm_sext = PC_W'($signed(ir[IMM_LSB +: IMM_W]));
    assign imm_abs  = PC_W'(ir[IMM_LSB +: IMM_W]);

    always_comb begin
        pc_next = pc_r;
        if (pc_rst) begin
            pc_next = RESET_VEC;
        end else if (pc_write && pc_upd_en) begin
            if (!pc_sel) begin
                pc_next = pc_r + PC_W'(1);
            end else if (br_sel) begin
                pc_next = imm_abs;
            end else begin
                // IR was fetched from pc-1, so the offset is relative to the next instruction
                pc_next = pc_r + imm_sext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_r <= RESET_VEC;
        end else begin
            pc_r <= pc_next;
        end
    end

`ifdef SISC_PREFETCH_EN
    // ------------------------------------------------------------------
    // Fetch FSM with one-entry sequential prefetch
    // ------------------------------------------------------------------
    logic               pf_pending;  // a prefetch of pc is owed (after reset / IR load)
    logic               pf_drop;     // in-flight prefetch was invalidated, drop its data
    logic               inval_now;
    logic               pf_match;
    logic               pf_ack_hit;
    logic               buf_hit;
    logic               buf_fill;
    logic               idle_hit;
    logic [INSTR_W-1:0] buf_data;

    // Any branch request or pc_rst kills speculation, even one the FSM ignores
    assign inval_now  = pc_rst || (pc_write && pc_sel);
    assign pf_match   = (imem_addr == pc_r);
    // Demand fetch satisfied directly by the prefetch returning this cycle
    assign pf_ack_hit = (state == ST_PREF) && imem_ack && !pf_drop && !pc_rst && ir_load && pf_match;
    assign idle_hit   = (state == ST_IDLE) && ir_load && buf_hit;
    assign buf_fill   = (state == ST_PREF) && imem_ack && !pf_drop && !inval_now && !pf_ack_hit;

    // PC frozen while a demand fetch is outstanding, like WAIT
    assign pc_upd_en  = (state == ST_IDLE) ||
                        ((state == ST_PREF) && (!ir_load || pf_ack_hit));

    assign fetch_busy = ((state == ST_IDLE) && ir_load && !buf_hit) ||
                        ((state == ST_WAIT) && !imem_ack) ||
                        ((state == ST_PREF) && ir_load && !pf_ack_hit);

    sisc_prefetch_buf #(
        .AW (PC_W),
        .DW (INSTR_W)
    ) u_pf_buf (
        .clk         (clk),
        .rst_f       (rst_f),
        .fill        (buf_fill),
        .fill_addr   (imem_addr),
        .fill_data   (imem_rdata),
        .inval       (inval_now),
        .consume     (idle_hit),
        .lookup_addr (pc_r),
        .hit         (buf_hit),
        .rd_data     (buf_data)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state      <= ST_IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            ir         <= INSTR_W'(IR_RESET);
            discard    <= 1'b0;
            pf_pending <= 1'b1;
            pf_drop    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ir_load) begin
                        if (buf_hit) begin
                            ir         <= buf_data;
                            pf_pending <= 1'b1;
                        end else begin
                            imem_addr <= pc_r;
                            imem_req  <= 1'b1;
                            discard   <= 1'b0;
                            state     <= ST_WAIT;
                        end
                    end else if (pf_pending && !pc_write && !pc_rst) begin
                        // Only speculate while pc is stable this cycle
                        imem_addr  <= pc_r;
                        imem_req   <= 1'b1;
                        pf_pending <= 1'b0;
                        pf_drop    <= 1'b0;
                        state      <= ST_PREF;
                    end else if (inval_now) begin
                        pf_pending <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (pc_rst) begin
                        discard <= 1'b1;
                    end
                    if (imem_ack) begin
                        if (!discard && !pc_rst) begin
                            ir         <= imem_rdata;
                            pf_pending <= 1'b1;
                        end
                        imem_req <= 1'b0;
                        discard  <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_PREF: begin
                    if (inval_now) begin
                        pf_drop <= 1'b1;
                    end
                    if (imem_ack) begin
                        if (pf_ack_hit) begin
                            ir         <= imem_rdata;
                            pf_pending <= 1'b1;
                        end
                        imem_req <= 1'b0;
                        pf_drop  <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end
`else
    // ------------------------------------------------------------------
    // Plain fetch FSM: one demand request per ir_load
    // ------------------------------------------------------------------
    assign pc_upd_en  = (state != ST_WAIT);
    assign fetch_busy = ((state == ST_IDLE) && ir_load) ||
                        ((state == ST_WAIT) && !imem_ack);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state     <= ST_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            ir        <= INSTR_W'(IR_RESET);
            discard   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // imem_ack here is a stray response and is ignored
                    if (ir_load) begin
                        imem_addr <= pc_r;
                        imem_req  <= 1'b1;
                        discard   <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pc_rst) begin
                        discard <= 1'b1;
                    end
                    if (imem_ack) begin
                        if (!discard && !pc_rst) begin
                            ir <= imem_rdata;
                        end
                        imem_req <= 1'b0;
                        discard  <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc     = pc_r;
    assign opcode = ir[OPCODE_LSB +: FIELD_W];
    assign mm     = ir[MM_LSB     +: FIELD_W];
    assign rd     = ir[RD_LSB     +: FIELD_W];
    assign rs     = ir[RS_LSB     +: FIELD_W];
    assign rt     = ir[RT_LSB     +: FIELD_W];
    assign imm    = ir[IMM_LSB    +: IMM_W];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit with a wait-state instruction memory model.
// Expected fetch addresses and IR words are queued at stimulus time and popped when the DUT delivers them.
// Inputs change and outputs are sampled on the falling clock edge; the memory responds 1 time unit after the rising edge.
module tb_sisc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        pc_rst = 1'b0;
    logic        pc_write = 1'b0;
    logic        pc_sel = 1'b0;
    logic        br_sel = 1'b0;
    logic        ir_load = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        fetch_busy;
    logic [15:0] pc;
    logic [3:0]  opcode, mm, rd, rs, rt;
    logic [15:0] imm;

    int          checks = 0;
    int          failures = 0;
    int          mem_wait = 0;
    int          wcnt = 0;
    int          ack_count = 0;
    int          a0;
    int          bc;
    bit          spur_ack = 1'b0;
    bit          done;
    logic [15:0] exp_pc = 16'h0;
    logic [31:0] ir_before;
    logic [15:0] exp_addr_q[$];
    logic [31:0] exp_ir_q[$];

    sisc_fetch_unit #(
        .PC_W      (16),
        .INSTR_W   (32),
        .RESET_VEC (16'h0000)
    ) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .pc_rst     (pc_rst),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_sel     (br_sel),
        .ir_load    (ir_load),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .fetch_busy (fetch_busy),
        .pc         (pc),
        .opcode     (opcode),
        .mm         (mm),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .imm        (imm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 32'h1A2B_3C4D;
            16'h0001: mem_word = 32'h4123_000F;
            16'h000F: mem_word = 32'h5C9A_FFFE;
            default:  mem_word = {a ^ 16'h3C5A, a};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory: acks mem_wait cycles after seeing the request, for exactly one cycle
    always @(posedge clk) begin
        logic [15:0] ea;
        #1;
        if (imem_ack) begin
            imem_ack = 1'b0;
        end else if (spur_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_req) begin
            if (wcnt == mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                ack_count++;
                wcnt = 0;
                if (exp_addr_q.size() != 0) begin
                    ea = exp_addr_q.pop_front();
                    chk("imem_addr", {16'h0, imem_addr}, {16'h0, ea});
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Fetch with increment, held while fetch_busy, then check IR and PC
    task automatic fetch_inc(input int wt, output int busy_cyc);
        logic [31:0] w;
        bit          fin;
        mem_wait = wt;
`ifndef SISC_PREFETCH_EN
        exp_addr_q.push_back(exp_pc);
`endif
        exp_ir_q.push_back(mem_word(exp_pc));
        exp_pc   = exp_pc + 16'd1;
        ir_load  = 1'b1;
        pc_write = 1'b1;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        busy_cyc = 0;
        fin      = 1'b0;
        for (int i = 0; i < 20 && !fin; i++) begin
            #1;
            if (!fetch_busy) fin = 1'b1;
            else begin
                busy_cyc++;
                @(negedge clk);
            end
        end
        chk("fetch_timeout", {31'h0, fin}, 32'h1);
        @(negedge clk);
        ir_load  = 1'b0;
        pc_write = 1'b0;
        w = exp_ir_q.pop_front();
        chk("ir_word", {opcode, mm, rd, rs, imm}, w);
        chk("ir_rt", {28'h0, rt}, {28'h0, w[15:12]});
        chk("pc_after_fetch", {16'h0, pc}, {16'h0, exp_pc});
    endtask

    task automatic pc_cmd(input logic w, input logic sel, input logic bsel, input logic rst);
        pc_write = w;
        pc_sel   = sel;
        br_sel   = bsel;
        pc_rst   = rst;
        @(negedge clk);
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_rst   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", {16'h0, imem_addr}, 32'h0);
        chk("rst_busy", {31'h0, fetch_busy}, 32'h0);
        chk("rst_ir", {opcode, mm, rd, rs, imm}, 32'h0);
        rst_f = 1'b1;

`ifdef SISC_PREFETCH_EN
        // Post-reset prefetch of word 0 makes the first fetch zero-stall
        repeat (3) @(negedge clk);
        fetch_inc(0, bc);
        chk("pf_first_busy", bc, 0);
        repeat (3) @(negedge clk);
        fetch_inc(0, bc);
        chk("pf_second_busy", bc, 0);
        // Let the prefetch of pc=2 land, then branch away: must stall
        repeat (3) @(negedge clk);
        pc_cmd(1'b1, 1'b1, 1'b1, 1'b0);
        exp_pc = 16'h000F;
        chk("pf_branch_pc", {16'h0, pc}, 32'h0000_000F);
        fetch_inc(0, bc);
        chk("pf_branch_busy", bc, 1);
        // Branch while a slow prefetch of 0x10 is in flight: it is dropped
        mem_wait = 3;
        @(negedge clk);
        chk("pf_inflight_req", {31'h0, imem_req}, 32'h1);
        pc_cmd(1'b1, 1'b1, 1'b1, 1'b0);
        exp_pc = 16'hFFFE;
        fetch_inc(3, bc);
        chk("pf_drop_stall", {31'h0, bc > 1}, 32'h1);
`else
        // Zero-wait fetch with increment
        fetch_inc(0, bc);
        chk("zw_busy_cycles", bc, 1);

        // 3-wait memory: one request, one increment
        a0 = ack_count;
        fetch_inc(3, bc);
        chk("w3_busy_cycles", bc, 4);
        chk("w3_single_req", ack_count - a0, 1);

        // Absolute branch to IR imm 0x000F
        pc_cmd(1'b1, 1'b1, 1'b1, 1'b0);
        exp_pc = 16'h000F;
        chk("br_abs_f", {16'h0, pc}, 32'h0000_000F);
        fetch_inc(1, bc);
        chk("w1_busy_cycles", bc, 2);

        // IR imm=0xFFFE, pc=0x0010
        pc_cmd(1'b1, 1'b1, 1'b0, 1'b0);
        chk("br_rel_neg", {16'h0, pc}, 32'h0000_000E);
        pc_cmd(1'b1, 1'b1, 1'b1, 1'b0);
        chk("br_abs_fffe", {16'h0, pc}, 32'h0000_FFFE);
        pc_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pc_inc_ffff", {16'h0, pc}, 32'h0000_FFFF);
        exp_pc = 16'hFFFF;
        fetch_inc(0, bc);   // wraps pc to 0x0000

        // pc_rst beats pc_write
        pc_cmd(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pc_inc_1", {16'h0, pc}, 32'h1);
        pc_cmd(1'b1, 1'b0, 1'b0, 1'b1);
        chk("pc_rst_vs_write", {16'h0, pc}, 32'h0);

        // pc_rst during WAIT: handshake completes, word discarded
        ir_before = {opcode, mm, rd, rs, imm};
        mem_wait  = 3;
        exp_addr_q.push_back(16'h0000);
        ir_load   = 1'b1;
        pc_write  = 1'b1;
        @(negedge clk);
        chk("wait_pc_inc", {16'h0, pc}, 32'h1);
        @(negedge clk);
        pc_rst = 1'b1;
        @(negedge clk);
        pc_rst = 1'b0;
        chk("pc_rst_in_wait", {16'h0, pc}, 32'h0);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (!fetch_busy) done = 1'b1;
            else @(negedge clk);
        end
        chk("discard_timeout", {31'h0, done}, 32'h1);
        @(negedge clk);
        ir_load  = 1'b0;
        pc_write = 1'b0;
        chk("ir_kept_discard", {opcode, mm, rd, rs, imm}, ir_before);
        chk("req_low_discard", {31'h0, imem_req}, 32'h0);
        chk("pc_after_discard", {16'h0, pc}, 32'h0);

        // Stray ack in IDLE is ignored
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        chk("spur_ir", {opcode, mm, rd, rs, imm}, ir_before);
        chk("spur_req", {31'h0, imem_req}, 32'h0);

        // Async reset in the middle of WAIT
        mem_wait = 3;
        ir_load  = 1'b1;
        pc_write = 1'b1;
        @(negedge clk);
        chk("mid_wait_pc", {16'h0, pc}, 32'h1);
        ir_load  = 1'b0;
        pc_write = 1'b0;
        @(negedge clk);
        chk("mid_wait_req", {31'h0, imem_req}, 32'h1);
        #2 rst_f = 1'b0;
        #1;
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_pc", {16'h0, pc}, 32'h0);
        chk("arst_ir", {opcode, mm, rd, rs, imm}, 32'h0);
        chk("arst_busy", {31'h0, fetch_busy}, 32'h0);
        @(negedge clk);
        rst_f  = 1'b1;
        exp_pc = 16'h0;
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
